// File: rtl/anc_fir_sequencer.sv
// anc_fir_sequencer
//   Per-sample controller for the adaptive FIR engine in the ANC datapath.
//   It accepts one reference/error pair per frame and forms the LMS weight-adjust
//   scalar (mu * error). It then launches one FIR run, waits for completion under
//   a timeout, and clips the result to the DAC width. Samples that arrive while a
//   run is in flight are dropped and counted.
//
// Ports
//   clk, rst_n            clock; synchronous active-low reset
//   sample_valid          strobe qualifying ref_sample / err_sample
//   ref_sample            signed reference sample, forwarded to the FIR as fir_x
//   err_sample            signed error-mic sample, scaled by mu into fir_wadj
//   mu                    unsigned step size, MU_FRAC fractional bits
//   adapt_en              0 freezes adaptation (fir_wadj = 0)
//   fir_go                one-cycle FIR start pulse
//   fir_x, fir_wadj       FIR operands, held for the whole run
//   fir_done, fir_out     FIR completion strobe and result
//   dac_sample, dac_valid clipped output sample and its strobe
//   busy                  controller not idle
//   overrun, overrun_cnt  sticky drop flag and saturating drop count
//   timeout_err           sticky flag, FIR failed to finish in time
module anc_fir_sequencer #(
  parameter int unsigned OUT_W   = 16,
  parameter int unsigned MU_FRAC = 15,
  parameter int unsigned TIMEOUT = 512,
  parameter int unsigned CNT_W   = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               sample_valid,
  input  logic [31:0]        ref_sample,
  input  logic [31:0]        err_sample,
  input  logic [15:0]        mu,
  input  logic               adapt_en,
  output logic               fir_go,
  output logic [31:0]        fir_x,
  output logic [31:0]        fir_wadj,
  input  logic               fir_done,
  input  logic [31:0]        fir_out,
  output logic [OUT_W-1:0]   dac_sample,
  output logic               dac_valid,
  output logic               busy,
  output logic               overrun,
  output logic [CNT_W-1:0]   overrun_cnt,
  output logic               timeout_err
);

  localparam int unsigned TmoW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [TmoW-1:0] TmoLast = TmoW'(TIMEOUT - 1);

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StOutput} state_e;

  state_e            state_q, state_d;
  logic [TmoW-1:0]   tmo_cnt_q, tmo_cnt_d, tmo_inc;
  logic              fir_go_q, fir_go_d;
  logic [31:0]       fir_x_q, fir_x_d;
  logic [31:0]       fir_wadj_q, fir_wadj_d;
  logic [OUT_W-1:0]  dac_sample_q, dac_sample_d;
  logic              dac_valid_q, dac_valid_d;
  logic              overrun_q, overrun_d;
  logic [CNT_W-1:0]  ovr_cnt_q, ovr_cnt_d;
  logic              timeout_err_q, timeout_err_d;

  logic signed [48:0] prod, prod_sh;
  logic [31:0]        wadj;
  logic [OUT_W-1:0]   clipped;

  // mu * err, floor-shifted by MU_FRAC, saturated to 32-bit signed.
  always_comb begin
    prod    = 49'(signed'(err_sample)) * 49'(signed'({1'b0, mu}));
    prod_sh = prod >>> MU_FRAC;
    if ((prod_sh[48:31] == '0) || (prod_sh[48:31] == '1)) begin
      wadj = prod_sh[31:0];
    end else if (prod_sh[48]) begin
      wadj = 32'h8000_0000;
    end else begin
      wadj = 32'h7FFF_FFFF;
    end
  end

  // Saturate fir_out into the signed DAC range.
  always_comb begin
    if ((fir_out[31:OUT_W-1] == '0) || (fir_out[31:OUT_W-1] == '1)) begin
      clipped = fir_out[OUT_W-1:0];
    end else if (fir_out[31]) begin
      clipped = {1'b1, {(OUT_W-1){1'b0}}};
    end else begin
      clipped = {1'b0, {(OUT_W-1){1'b1}}};
    end
  end

  assign tmo_inc = tmo_cnt_q + TmoW'(1);

  always_comb begin
    state_d       = state_q;
    tmo_cnt_d     = tmo_cnt_q;
    fir_go_d      = 1'b0;
    fir_x_d       = fir_x_q;
    fir_wadj_d    = fir_wadj_q;
    dac_sample_d  = dac_sample_q;
    dac_valid_d   = 1'b0;
    overrun_d     = overrun_q;
    ovr_cnt_d     = ovr_cnt_q;
    timeout_err_d = timeout_err_q;

    // Only a strobe seen while the state register is idle is accepted.
    if (sample_valid && (state_q != StIdle)) begin
      overrun_d = 1'b1;
      if (ovr_cnt_q != '1) begin
        ovr_cnt_d = ovr_cnt_q + CNT_W'(1);
      end
    end

    unique case (state_q)
      StIdle: begin
        if (sample_valid) begin
          fir_x_d    = ref_sample;
          fir_wadj_d = adapt_en ? wadj : 32'h0;
          fir_go_d   = 1'b1;
          state_d    = StIssue;
        end
      end
      StIssue: begin
        tmo_cnt_d = '0;
        state_d   = StWait;
      end
      StWait: begin
        if (fir_done) begin
          dac_sample_d = clipped;
          dac_valid_d  = 1'b1;
          state_d      = StOutput;
        end else if (tmo_inc == TmoLast) begin
          // Abort: emit a muted frame so the DAC stream keeps its cadence.
          timeout_err_d = 1'b1;
          dac_sample_d  = '0;
          dac_valid_d   = 1'b1;
          state_d       = StIdle;
        end else begin
          tmo_cnt_d = tmo_inc;
        end
      end
      StOutput: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= StIdle;
      tmo_cnt_q     <= '0;
      fir_go_q      <= 1'b0;
      fir_x_q       <= '0;
      fir_wadj_q    <= '0;
      dac_sample_q  <= '0;
      dac_valid_q   <= 1'b0;
      overrun_q     <= 1'b0;
      ovr_cnt_q     <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      tmo_cnt_q     <= tmo_cnt_d;
      fir_go_q      <= fir_go_d;
      fir_x_q       <= fir_x_d;
      fir_wadj_q    <= fir_wadj_d;
      dac_sample_q  <= dac_sample_d;
      dac_valid_q   <= dac_valid_d;
      overrun_q     <= overrun_d;
      ovr_cnt_q     <= ovr_cnt_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign fir_go      = fir_go_q;
  assign fir_x       = fir_x_q;
  assign fir_wadj    = fir_wadj_q;
  assign dac_sample  = dac_sample_q;
  assign dac_valid   = dac_valid_q;
  assign busy        = (state_q != StIdle);
  assign overrun     = overrun_q;
  assign overrun_cnt = ovr_cnt_q;
  assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_anc_fir_sequencer.sv
// Directed bench for anc_fir_sequencer: a vector table of complete frames plus
// hand-written sequences for overrun, timeout and mid-run reset.
module tb_anc_fir_sequencer;

  localparam int OutW    = 16;
  localparam int Timeout = 512;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            sample_valid;
  logic [31:0]     ref_sample, err_sample;
  logic [15:0]     mu;
  logic            adapt_en;
  logic            fir_go;
  logic [31:0]     fir_x, fir_wadj;
  logic            fir_done;
  logic [31:0]     fir_out;
  logic [OutW-1:0] dac_sample;
  logic            dac_valid, busy, overrun, timeout_err;
  logic [7:0]      overrun_cnt;

  anc_fir_sequencer #(
    .OUT_W   (OutW),
    .MU_FRAC (15),
    .TIMEOUT (Timeout),
    .CNT_W   (8)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .sample_valid (sample_valid),
    .ref_sample   (ref_sample),
    .err_sample   (err_sample),
    .mu           (mu),
    .adapt_en     (adapt_en),
    .fir_go       (fir_go),
    .fir_x        (fir_x),
    .fir_wadj     (fir_wadj),
    .fir_done     (fir_done),
    .fir_out      (fir_out),
    .dac_sample   (dac_sample),
    .dac_valid    (dac_valid),
    .busy         (busy),
    .overrun      (overrun),
    .overrun_cnt  (overrun_cnt),
    .timeout_err  (timeout_err)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;
  int go_cnt   = 0;
  int dv_cnt   = 0;

  always @(negedge clk) begin
    if (fir_go) go_cnt++;
    if (dac_valid) dv_cnt++;
  end

  typedef struct {
    logic [31:0] ref_s;
    logic [31:0] err_s;
    logic [15:0] mu_v;
    logic        adapt;
    logic [31:0] fout;
    int          delay;
    logic [31:0] exp_wadj;
    logic [31:0] exp_dac;
  } vec_t;

  vec_t vecs [6];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_assert++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  function automatic logic [31:0] dac32();
    return 32'($signed(dac_sample));
  endfunction

  // One full frame: capture, issue, wait v.delay cycles, done, output.
  task automatic run_frame(input vec_t v, input int idx);
    int go0;
    go0          = go_cnt;
    sample_valid = 1'b1;
    ref_sample   = v.ref_s;
    err_sample   = v.err_s;
    mu           = v.mu_v;
    adapt_en     = v.adapt;
    tick();
    // Scramble inputs: they must only matter in the capture cycle.
    sample_valid = 1'b0;
    ref_sample   = 32'hA5A5_A5A5;
    err_sample   = 32'h1234_5678;
    mu           = 16'hDEAD;
    adapt_en     = ~v.adapt;
    chk($sformatf("v%0d fir_go", idx), 32'(fir_go), 32'd1);
    chk($sformatf("v%0d fir_x", idx), fir_x, v.ref_s);
    chk($sformatf("v%0d fir_wadj", idx), fir_wadj, v.exp_wadj);
    chk($sformatf("v%0d busy", idx), 32'(busy), 32'd1);
    repeat (v.delay) tick();
    fir_done = 1'b1;
    fir_out  = v.fout;
    chk($sformatf("v%0d fir_x held", idx), fir_x, v.ref_s);
    chk($sformatf("v%0d fir_wadj held", idx), fir_wadj, v.exp_wadj);
    chk($sformatf("v%0d dac_valid early", idx), 32'(dac_valid), 32'd0);
    tick();
    fir_done = 1'b0;
    fir_out  = 32'h5555_5555;
    chk($sformatf("v%0d dac_valid", idx), 32'(dac_valid), 32'd1);
    chk($sformatf("v%0d dac_sample", idx), dac32(), v.exp_dac);
    chk($sformatf("v%0d one go", idx), 32'(go_cnt - go0), 32'd1);
    tick();
    chk($sformatf("v%0d dac_valid drop", idx), 32'(dac_valid), 32'd0);
    chk($sformatf("v%0d idle", idx), 32'(busy), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int go0, dv0;

    vecs[0] = '{32'd100, 32'd1000, 16'h4000, 1'b1, 32'd1234, 131, 32'd500, 32'd1234};
    vecs[1] = '{-32'sd7, -32'sd1000, 16'h4000, 1'b1, 32'd40000, 5, -32'sd500, 32'd32767};
    vecs[2] = '{-32'sd7, -32'sd1000, 16'h4000, 1'b0, -32'sd40000, 1, 32'd0, -32'sd32768};
    vecs[3] = '{32'd9, 32'h7FFF_FFFF, 16'hFFFF, 1'b1, -32'sd5, 3, 32'h7FFF_FFFF, -32'sd5};
    vecs[4] = '{32'd8, 32'h8000_0000, 16'hFFFF, 1'b1, 32'd0, 10, 32'h8000_0000, 32'd0};
    vecs[5] = '{32'd7, 32'h4000_0000, 16'hFFFF, 1'b1, 32'd32767, 2, 32'h7FFF_8000, 32'd32767};

    rst_n        = 1'b0;
    sample_valid = 1'b1;
    ref_sample   = 32'd1;
    err_sample   = 32'd1;
    mu           = 16'h4000;
    adapt_en     = 1'b1;
    fir_done     = 1'b1;
    fir_out      = 32'd99;
    tick();
    tick();
    chk("reset fir_go", 32'(fir_go), 32'd0);
    chk("reset fir_x", fir_x, 32'd0);
    chk("reset dac_valid", 32'(dac_valid), 32'd0);
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset overrun_cnt", 32'(overrun_cnt), 32'd0);
    chk("reset timeout_err", 32'(timeout_err), 32'd0);
    rst_n        = 1'b1;
    sample_valid = 1'b0;
    fir_done     = 1'b0;
    tick();
    chk("post-reset fir_go", 32'(fir_go), 32'd0);
    tick();

    for (int i = 0; i < 6; i++) run_frame(vecs[i], i);
    chk("no overrun yet", 32'(overrun), 32'd0);

    // Three drops during WAIT.
    go0          = go_cnt;
    sample_valid = 1'b1;
    ref_sample   = 32'd5;
    err_sample   = 32'd0;
    tick();
    sample_valid = 1'b0;
    tick();
    for (int k = 0; k < 3; k++) begin
      sample_valid = 1'b1;
      tick();
      sample_valid = 1'b0;
      tick();
    end
    fir_done = 1'b1;
    fir_out  = 32'd9;
    tick();
    fir_done = 1'b0;
    chk("ovr dac_sample", dac32(), 32'd9);
    tick();
    chk("ovr one go", 32'(go_cnt - go0), 32'd1);
    chk("ovr flag", 32'(overrun), 32'd1);
    chk("ovr cnt 3", 32'(overrun_cnt), 32'd3);

    // 300 drops saturate the counter.
    go0          = go_cnt;
    sample_valid = 1'b1;
    tick();
    repeat (300) tick();
    sample_valid = 1'b0;
    fir_done     = 1'b1;
    fir_out      = 32'd77;
    tick();
    fir_done = 1'b0;
    chk("sat dac_sample", dac32(), 32'd77);
    tick();
    chk("sat one go", 32'(go_cnt - go0), 32'd1);
    chk("sat cnt 255", 32'(overrun_cnt), 32'd255);

    // Timeout: done never arrives.
    sample_valid = 1'b1;
    ref_sample   = 32'd11;
    err_sample   = 32'd2000;
    mu           = 16'h4000;
    adapt_en     = 1'b1;
    tick();
    sample_valid = 1'b0;
    chk("tmo wadj", fir_wadj, 32'd1000);
    repeat (Timeout - 1) tick();
    chk("tmo not yet valid", 32'(dac_valid), 32'd0);
    chk("tmo not yet err", 32'(timeout_err), 32'd0);
    chk("tmo still busy", 32'(busy), 32'd1);
    tick();
    chk("tmo dac_valid", 32'(dac_valid), 32'd1);
    chk("tmo dac_sample", dac32(), 32'd0);
    chk("tmo err", 32'(timeout_err), 32'd1);
    chk("tmo idle", 32'(busy), 32'd0);
    chk("tmo fir_x held", fir_x, 32'd11);
    sample_valid = 1'b1;
    ref_sample   = 32'd22;
    err_sample   = 32'd0;
    tick();
    sample_valid = 1'b0;
    chk("tmo next go", 32'(fir_go), 32'd1);
    chk("tmo next fir_x", fir_x, 32'd22);
    repeat (2) tick();
    fir_done = 1'b1;
    fir_out  = 32'd3;
    tick();
    fir_done = 1'b0;
    chk("tmo next dac", dac32(), 32'd3);
    tick();

    // Reset in the middle of WAIT.
    sample_valid = 1'b1;
    ref_sample   = 32'd33;
    err_sample   = 32'd1000;
    tick();
    sample_valid = 1'b0;
    repeat (3) tick();
    rst_n = 1'b0;
    tick();
    chk("mid rst fir_go", 32'(fir_go), 32'd0);
    chk("mid rst fir_x", fir_x, 32'd0);
    chk("mid rst fir_wadj", fir_wadj, 32'd0);
    chk("mid rst dac_sample", dac32(), 32'd0);
    chk("mid rst dac_valid", 32'(dac_valid), 32'd0);
    chk("mid rst busy", 32'(busy), 32'd0);
    chk("mid rst overrun", 32'(overrun), 32'd0);
    chk("mid rst overrun_cnt", 32'(overrun_cnt), 32'd0);
    chk("mid rst timeout_err", 32'(timeout_err), 32'd0);
    rst_n = 1'b1;
    dv0   = dv_cnt;
    tick();
    chk("mid rst no go", 32'(fir_go), 32'd0);
    fir_done = 1'b1;
    fir_out  = 32'd500;
    tick();
    fir_done = 1'b0;
    repeat (3) tick();
    chk("mid rst no dac_valid", 32'(dv_cnt - dv0), 32'd0);
    chk("mid rst stays idle", 32'(busy), 32'd0);

    run_frame(vecs[0], 6);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/anc_fir_sequencer.md
Name: anc_fir_sequencer

Overview:
Per-sample controller for the adaptive FIR engine in the ANC datapath.
- Accepts one reference/error sample pair per audio frame.
- Computes the LMS weight-update scalar (mu × error).
- Launches one FIR run with a go pulse and waits for done, bounded by a timeout.
- Clips the FIR result to the DAC width.
- Drops any sample that arrives while a run is in flight, and counts the drops.

Parameters:
OUT_W, 16, DAC sample width in bits (signed).
MU_FRAC, 15, fractional bits of mu; product shifted right arithmetically by this amount.
TIMEOUT, 512, max cycles in WAIT before abort; must exceed FIR run length (taps+3).
CNT_W, 8, overrun counter width.

Ports:
clk  in  1  system clock.
rst_n  in  1  reset; synchronous, active-low.
sample_valid  in  1  one-cycle strobe; ref_sample/err_sample valid.
ref_sample  in  32  signed reference (feedforward) sample.
err_sample  in  32  signed error-microphone sample.
mu  in  16  unsigned step size, Q(16-MU_FRAC).MU_FRAC.
adapt_en  in  1  0 = freeze weights (fir_wadj forced 0).
fir_go  out  1  one-cycle start pulse to FIR engine.
fir_x  out  32  signed sample to FIR feedforward input; held until done.
fir_wadj  out  32  signed weight-adjust to FIR; held until done.
fir_done  in  1  FIR completion strobe.
fir_out  in  32  signed FIR result, valid with fir_done.
dac_sample  out  OUT_W  signed clipped output sample.
dac_valid  out  1  one-cycle strobe for dac_sample.
busy  out  1  high in any state other than IDLE.
overrun  out  1  sticky; set on a dropped sample, cleared only by reset.
overrun_cnt  out  CNT_W  dropped-sample count, saturating at all-ones.
timeout_err  out  1  sticky; set on WAIT timeout, cleared only by reset.

Behaviour:
Reset (rst_n low at a clk edge):
- All outputs go to 0; state goes to IDLE; timeout counter goes to 0.
- Reset wins over every other event, including mid-run. fir_go is never asserted in the cycle after reset.

FSM states: IDLE, ISSUE, WAIT, OUTPUT.
- IDLE: on sample_valid, register fir_x <= ref_sample and fir_wadj <= wadj; go to ISSUE.
- ISSUE: fir_go = 1 for exactly this cycle; clear timeout counter; go to WAIT.
- WAIT, fir_done = 1: register clip(fir_out); go to OUTPUT.
- WAIT, counter reaches TIMEOUT-1 without done: set timeout_err; drive dac_sample = 0 with dac_valid = 1 (mute frame); go to IDLE.
- OUTPUT: dac_valid = 1 for this cycle, dac_sample = the clipped value; go to IDLE.
- fir_done seen outside WAIT is ignored.

wadj computation:
- prod = signed(err_sample) × signed({1'b0, mu}), 49-bit.
- Shift: prod >>> MU_FRAC (arithmetic, floor).
- Saturate to [0x80000000, 0x7FFFFFFF].
- wadj = 0 when adapt_en = 0.
- adapt_en and mu are sampled only in the IDLE capture cycle.

Clip: fir_out is saturated to [-2^(OUT_W-1), 2^(OUT_W-1)-1].

Timing and latency:
- sample_valid at cycle 0 -> fir_go at cycle 1.
- fir_done at cycle k -> dac_valid at cycle k+1.
- fir_x and fir_wadj remain stable from cycle 1 until the cycle after done or timeout.

Overrun:
- sample_valid in any state other than IDLE: sample dropped, overrun set, overrun_cnt increments (holds at max).
- sample_valid in the same cycle as OUTPUT->IDLE is a drop. Only a strobe while the state register is IDLE is accepted.

busy = (state != IDLE).

Test Plan:
- Nominal: mu=0x4000, adapt_en=1, ref=100, err=1000; FIR model returns done after 131 cycles with fir_out=1234 -> fir_go at cycle 1, fir_x=100, fir_wadj=500, dac_sample=1234 with dac_valid one cycle after done.
- Sign and freeze: err=-1000, mu=0x4000 -> fir_wadj=-500; same stimulus with adapt_en=0 -> fir_wadj=0.
- wadj saturation: mu=0xFFFF; err=0x7FFFFFFF -> fir_wadj=0x7FFFFFFF; err=0x80000000 -> fir_wadj=0x80000000; err=0x40000000 -> fir_wadj=0x7FFF8000.
- DAC clip: fir_out=40000 -> 32767; fir_out=-40000 -> -32768; fir_out=-5 -> -5.
- Overrun: 3 extra sample_valid pulses during WAIT -> exactly one fir_go, overrun=1, overrun_cnt=3; 300 pulses -> overrun_cnt=255.
- Timeout and reset: FIR model never asserts done -> timeout_err=1 and dac_valid with dac_sample=0 at cycle 1+TIMEOUT, next sample accepted. Separately, rst_n low mid-WAIT -> all outputs 0, busy=0, no dac_valid afterwards.
